// File: rtl/lzw_stream_encoder_if.sv
// ---------------------------------------------------------------------------
// lzw_stream_encoder_if
// Bundles the symbol stream, code stream and status lines of the LZW
// stream encoder.
//   sym_i / sym_valid_i / sym_last_i / sym_ready_o : symbol input handshake
//   code_o / code_valid_o / code_last_o / code_ready_i : code output handshake
//   dict_size_o : next free dictionary code
//   busy_o      : encoder holds a string or has a code pending internally
// Modports:
//   master : the environment (drives symbols, accepts codes)
//   slave  : the encoder itself
// ---------------------------------------------------------------------------
interface lzw_stream_encoder_if #(
  parameter int SYM_W  = 8,
  parameter int CODE_W = 10
);
  logic [SYM_W-1:0]  sym_i;
  logic              sym_valid_i;
  logic              sym_last_i;
  logic              sym_ready_o;
  logic [CODE_W-1:0] code_o;
  logic              code_valid_o;
  logic              code_last_o;
  logic              code_ready_i;
  logic [CODE_W:0]   dict_size_o;
  logic              busy_o;

  modport master (
    output sym_i, sym_valid_i, sym_last_i, code_ready_i,
    input  sym_ready_o, code_o, code_valid_o, code_last_o, dict_size_o, busy_o
  );

  modport slave (
    input  sym_i, sym_valid_i, sym_last_i, code_ready_i,
    output sym_ready_o, code_o, code_valid_o, code_last_o, dict_size_o, busy_o
  );
endinterface

// File: rtl/lzw_stream_encoder.sv
// ---------------------------------------------------------------------------
// lzw_stream_encoder
// Streaming LZW compressor. Symbols arrive one per handshake; codes leave
// through a single registered output stage. The dictionary holds
// (prefix code, symbol) pairs for codes FIRST..MAX and is searched in one
// cycle by comparing every live entry in parallel.
// Ports:
//   clk_i   : clock, all state changes on the rising edge
//   reset_i : synchronous active-high reset
//   bus     : lzw_stream_encoder_if.slave (symbol in, code out, status)
// Parameters:
//   SYM_W      : symbol width
//   CODE_W     : code width (SYM_W+2 .. 12)
//   FULL_RESET : 0 = freeze dictionary when full, 1 = emit CLEAR and restart
// ---------------------------------------------------------------------------
module lzw_stream_encoder #(
  parameter int SYM_W      = 8,
  parameter int CODE_W     = 10,
  parameter int FULL_RESET = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  lzw_stream_encoder_if.slave   bus
);

  localparam int LIT_N   = 1 << SYM_W;
  localparam int FIRST_I = LIT_N + 1;
  localparam int MAX_I   = (1 << CODE_W) - 1;
  localparam int N_ENT   = MAX_I - FIRST_I + 1;
  localparam int IW      = $clog2(N_ENT);
  localparam int DW      = CODE_W + 1;

  localparam logic [CODE_W:0]   FIRST_D = DW'(FIRST_I);
  localparam logic [CODE_W:0]   MAX_D   = DW'(MAX_I);
  localparam logic [CODE_W-1:0] CLEAR_C = CODE_W'(LIT_N);

  typedef enum logic [1:0] {IDLE, ACCUM, CLR, FLUSH} state_t;

  state_t            state_reg;
  logic [CODE_W-1:0] w_reg;
  logic [CODE_W-1:0] code_reg;
  logic              code_valid_reg;
  logic              code_last_reg;
  logic [CODE_W:0]   dict_size_reg;
  logic              last_pend_reg;

  // Dictionary storage. Kept in flops because every entry is compared
  // against the current (W, symbol) pair each cycle.
  logic [CODE_W-1:0] prefix_mem [N_ENT];
  logic [SYM_W-1:0]  sym_mem    [N_ENT];

  logic              out_free;
  logic              sym_ready;
  logic              sym_fire;
  logic [N_ENT-1:0]  match;
  logic              hit;
  logic [CODE_W-1:0] hit_code;
  logic              alloc;
  logic [IW-1:0]     wr_idx;

  // The output register can take a new code if empty or being drained now.
  assign out_free  = !code_valid_reg || bus.code_ready_i;
  assign sym_ready = ((state_reg == IDLE) || (state_reg == ACCUM)) && out_free;
  assign sym_fire  = bus.sym_valid_i && sym_ready;

  // Entry gi holds code FIRST+gi; it only counts while below dict_size, so
  // stale entries left behind by a CLEAR can never match.
  genvar gi;
  generate
    for (gi = 0; gi < N_ENT; gi++) begin : g_ent
      localparam logic [CODE_W:0] ENT_CODE = DW'(FIRST_I + gi);
      assign match[gi] = (ENT_CODE < dict_size_reg) &&
                         (prefix_mem[gi] == w_reg) &&
                         (sym_mem[gi] == bus.sym_i);
    end
  endgenerate

  // LZW never stores the same (prefix, symbol) pair twice among live
  // entries, so at most one bit of match is set and an OR-merge suffices.
  always_comb begin
    hit      = 1'b0;
    hit_code = '0;
    for (int i = 0; i < N_ENT; i++) begin
      if (match[i]) begin
        hit      = 1'b1;
        hit_code = hit_code | CODE_W'(FIRST_I + i);
      end
    end
  end

  assign alloc  = sym_fire && (state_reg == ACCUM) && !hit &&
                  (dict_size_reg <= MAX_D) && !reset_i;
  assign wr_idx = IW'(dict_size_reg - FIRST_D);

  always_ff @(posedge clk_i) begin
    if (alloc) begin
      prefix_mem[wr_idx] <= w_reg;
      sym_mem[wr_idx]    <= bus.sym_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      w_reg          <= '0;
      code_reg       <= '0;
      code_valid_reg <= 1'b0;
      code_last_reg  <= 1'b0;
      dict_size_reg  <= FIRST_D;
      last_pend_reg  <= 1'b0;
    end else begin
      // Drain by default; a newly registered code below overrides this.
      if (code_valid_reg && bus.code_ready_i) code_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (sym_fire) begin
            w_reg <= CODE_W'(bus.sym_i);
            if (bus.sym_last_i) begin
              code_reg       <= CODE_W'(bus.sym_i);
              code_valid_reg <= 1'b1;
              code_last_reg  <= 1'b1;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (sym_fire) begin
            if (hit) begin
              w_reg <= hit_code;
              if (bus.sym_last_i) begin
                code_reg       <= hit_code;
                code_valid_reg <= 1'b1;
                code_last_reg  <= 1'b1;
                state_reg      <= IDLE;
              end
            end else begin
              code_reg       <= w_reg;
              code_valid_reg <= 1'b1;
              code_last_reg  <= 1'b0;
              w_reg          <= CODE_W'(bus.sym_i);
              if (dict_size_reg <= MAX_D) dict_size_reg <= dict_size_reg + 1'b1;
              // Allocating MAX fills the table; in restart mode a CLEAR must
              // follow, and a pending last flag is replayed after it.
              if ((FULL_RESET != 0) && (dict_size_reg == MAX_D)) begin
                state_reg     <= CLR;
                last_pend_reg <= bus.sym_last_i;
              end else if (bus.sym_last_i) begin
                state_reg <= FLUSH;
              end
            end
          end
        end

        CLR: begin
          if (out_free) begin
            code_reg       <= CLEAR_C;
            code_valid_reg <= 1'b1;
            code_last_reg  <= 1'b0;
            dict_size_reg  <= FIRST_D;
            state_reg      <= last_pend_reg ? FLUSH : ACCUM;
          end
        end

        FLUSH: begin
          if (out_free) begin
            code_reg       <= w_reg;
            code_valid_reg <= 1'b1;
            code_last_reg  <= 1'b1;
            state_reg      <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.sym_ready_o  = sym_ready;
  assign bus.code_o       = code_reg;
  assign bus.code_valid_o = code_valid_reg;
  assign bus.code_last_o  = code_last_reg;
  assign bus.dict_size_o  = dict_size_reg;
  assign bus.busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_lzw_stream_encoder.sv
// ---------------------------------------------------------------------------
// tb_lzw_stream_encoder
// Three encoder instances (default, 9-bit restart, 9-bit freeze) share one
// stimulus process; sel chooses which one is driven and observed. A
// behavioural LZW encoder predicts each code into a queue as symbols are
// accepted; codes leaving the DUT are popped and compared. Long streams are
// also decoded independently and compared against the input.
// ---------------------------------------------------------------------------
module tb_lzw_stream_encoder;

  logic clk;
  logic tb_rst;
  logic [7:0] tb_sym;
  logic tb_valid, tb_last, tb_cready;
  int   sel;

  int   o_code, o_dsize;
  logic o_cvalid, o_clast, o_sready, o_busy;

  int errors = 0;
  int checks = 0;
  int test_id = 0;
  bit stall_mode, gap_mode;
  int clears;

  int sym_q[$];
  bit last_q[$];
  int rnd_q[$];
  int exp_code_q[$];
  bit exp_last_q[$];
  int got_code_q[$];
  bit got_last_q[$];

  int t1_codes[10] = '{'h062, 'h061, 'h06E, 'h102, 'h061,
                       'h05F, 'h101, 'h06E, 'h064, 'h104};

  // behavioural encoder state
  int m_dict[int];
  int m_size, m_max, m_w;
  bit m_fr, m_active;

  lzw_stream_encoder_if #(.SYM_W(8), .CODE_W(10)) if0();
  lzw_stream_encoder_if #(.SYM_W(8), .CODE_W(9))  if1();
  lzw_stream_encoder_if #(.SYM_W(8), .CODE_W(9))  if2();

  lzw_stream_encoder #(.SYM_W(8), .CODE_W(10), .FULL_RESET(0)) u_dut0 (
    .clk_i(clk), .reset_i(tb_rst), .bus(if0.slave));
  lzw_stream_encoder #(.SYM_W(8), .CODE_W(9), .FULL_RESET(1)) u_dut1 (
    .clk_i(clk), .reset_i(tb_rst), .bus(if1.slave));
  lzw_stream_encoder #(.SYM_W(8), .CODE_W(9), .FULL_RESET(0)) u_dut2 (
    .clk_i(clk), .reset_i(tb_rst), .bus(if2.slave));

  assign if0.sym_i = tb_sym;
  assign if1.sym_i = tb_sym;
  assign if2.sym_i = tb_sym;
  assign if0.sym_last_i = tb_last;
  assign if1.sym_last_i = tb_last;
  assign if2.sym_last_i = tb_last;
  assign if0.sym_valid_i = tb_valid && (sel == 0);
  assign if1.sym_valid_i = tb_valid && (sel == 1);
  assign if2.sym_valid_i = tb_valid && (sel == 2);
  assign if0.code_ready_i = (sel == 0) ? tb_cready : 1'b1;
  assign if1.code_ready_i = (sel == 1) ? tb_cready : 1'b1;
  assign if2.code_ready_i = (sel == 2) ? tb_cready : 1'b1;

  always_comb begin
    o_code = int'(if0.code_o); o_dsize = int'(if0.dict_size_o);
    o_cvalid = if0.code_valid_o; o_clast = if0.code_last_o;
    o_sready = if0.sym_ready_o; o_busy = if0.busy_o;
    if (sel == 1) begin
      o_code = int'(if1.code_o); o_dsize = int'(if1.dict_size_o);
      o_cvalid = if1.code_valid_o; o_clast = if1.code_last_o;
      o_sready = if1.sym_ready_o; o_busy = if1.busy_o;
    end else if (sel == 2) begin
      o_code = int'(if2.code_o); o_dsize = int'(if2.dict_size_o);
      o_cvalid = if2.code_valid_o; o_clast = if2.code_last_o;
      o_sready = if2.sym_ready_o; o_busy = if2.busy_o;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL t%0d %s: got 0x%0h, expected 0x%0h", test_id, tag, got, exp);
    end
  endtask

  task automatic push_exp(input int c, input bit l);
    exp_code_q.push_back(c);
    exp_last_q.push_back(l);
  endtask

  task automatic m_reset(input int cw, input bit fr);
    m_dict.delete();
    m_size = 257; m_max = (1 << cw) - 1; m_fr = fr; m_active = 0; m_w = 0;
    exp_code_q.delete(); exp_last_q.delete();
    got_code_q.delete(); got_last_q.delete();
    clears = 0;
  endtask

  // Textbook LZW with a hash map keyed by (prefix, symbol).
  task automatic m_step(input int c, input bit last);
    int key;
    key = m_w * 256 + c;
    if (!m_active) begin
      if (last) push_exp(c, 1'b1);
      else begin m_w = c; m_active = 1; end
    end else if (m_dict.exists(key)) begin
      m_w = m_dict[key];
      if (last) begin push_exp(m_w, 1'b1); m_active = 0; end
    end else begin
      push_exp(m_w, 1'b0);
      if (m_size <= m_max) begin m_dict[key] = m_size; m_size++; end
      if (m_fr && m_size == m_max + 1) begin
        push_exp(256, 1'b0);
        m_dict.delete();
        m_size = 257;
      end
      m_w = c;
      if (last) begin push_exp(m_w, 1'b1); m_active = 0; end
    end
  endtask

  task automatic do_reset(input int s);
    sel = s; tb_valid = 0; tb_last = 0; tb_cready = 1; tb_rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tb_rst = 0;
    #1;
    check("rst_code_valid", int'(o_cvalid), 0);
    check("rst_code_last", int'(o_clast), 0);
    check("rst_code", o_code, 0);
    check("rst_dict_size", o_dsize, 257);
    check("rst_busy", int'(o_busy), 0);
    check("rst_sym_ready", int'(o_sready), 1);
  endtask

  task automatic load_banana();
    string s;
    s = "banana_bandana";
    sym_q.delete(); last_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      sym_q.push_back(int'(s[i]));
      last_q.push_back(i == s.len() - 1);
    end
  endtask

  // Drive sym_q into the selected DUT and score its output. With
  // stop_after >= 0 the task returns (before the next edge) once that many
  // symbols were accepted and a code is on the output.
  task automatic run_stream(input int stop_after);
    int idx = 0, hold = 0, cyc = 0, n_before;
    bit want_valid = 0, done = 0;
    while (!done) begin
      @(negedge clk);
      if (o_cvalid && stall_mode && hold < 3) begin tb_cready = 0; hold++; end
      else tb_cready = 1;
      if (idx < sym_q.size() && (!gap_mode || $urandom_range(0, 3) != 0)) begin
        tb_valid = 1; tb_sym = 8'(sym_q[idx]); tb_last = last_q[idx];
      end else begin
        tb_valid = 0; tb_sym = 8'($urandom_range(0, 255)); tb_last = 1'($urandom_range(0, 1));
      end
      #1;
      if (want_valid) check("latency_code_valid", int'(o_cvalid), 1);
      want_valid = 0;
      if (!tb_cready) check("stall_sym_ready", int'(o_sready), 0);
      if (o_cvalid) begin
        if (exp_code_q.size() == 0) check("spurious_code_valid", int'(o_cvalid), 0);
        else begin
          check("code", o_code, exp_code_q[0]);
          check("code_last", int'(o_clast), int'(exp_last_q[0]));
          if (tb_cready) begin
            $display("[%0t] t%0d code=0x%03h last=%0b dict=%0d", $time, test_id,
                     o_code, o_clast, o_dsize);
            if (o_code == 256) begin
              check("clear_dict_size", o_dsize, 257);
              clears++;
            end
            got_code_q.push_back(o_code);
            got_last_q.push_back(o_clast);
            void'(exp_code_q.pop_front());
            void'(exp_last_q.pop_front());
            hold = 0;
          end
        end
      end
      if (stop_after >= 0 && idx >= stop_after && o_cvalid) begin
        tb_valid = 0;
        return;
      end
      if (tb_valid && o_sready) begin
        n_before = exp_code_q.size();
        m_step(sym_q[idx], last_q[idx]);
        want_valid = (exp_code_q.size() > n_before);
        idx++;
      end
      if (idx >= sym_q.size() && exp_code_q.size() == 0) done = 1;
      cyc++;
      if (!done && cyc > 20000) begin
        check("timeout_symbols_left", sym_q.size() - idx, 0);
        check("timeout_codes_left", exp_code_q.size(), 0);
        done = 1;
      end
    end
    tb_valid = 0;
  endtask

  task automatic after_stream();
    @(negedge clk);
    #1;
    check("end_code_valid", int'(o_cvalid), 0);
    check("end_busy", int'(o_busy), 0);
    check("end_dict_size_model", o_dsize, m_size);
  endtask

  task automatic check_banana();
    check("t1_code_count", got_code_q.size(), 10);
    for (int i = 0; i < 10 && i < got_code_q.size(); i++) begin
      check($sformatf("t1_code[%0d]", i), got_code_q[i], t1_codes[i]);
      check($sformatf("t1_last[%0d]", i), int'(got_last_q[i]), (i == 9) ? 1 : 0);
    end
    check("t1_dict_size", o_dsize, 266);
  endtask

  // Independent LZW decoder over the collected codes.
  task automatic decode_check(input string tag, input int cw);
    int pre[int];
    int sy[int];
    int outq[$];
    int str[$];
    int size = 257, prev = -1, maxc, mism = 0, k, t;
    bit kwk;
    maxc = (1 << cw) - 1;
    for (int i = 0; i < got_code_q.size(); i++) begin
      k = got_code_q[i];
      if (k == 256) begin size = 257; prev = -1; continue; end
      kwk = (k == size) && (prev >= 0);
      if (k >= size && !kwk) begin mism++; prev = -1; continue; end
      str.delete();
      t = kwk ? prev : k;
      while (t >= 257) begin str.push_front(sy[t]); t = pre[t]; end
      str.push_front(t);
      if (kwk) str.push_back(str[0]);
      if (prev >= 0 && size <= maxc) begin pre[size] = prev; sy[size] = str[0]; size++; end
      prev = got_last_q[i] ? -1 : k;
      foreach (str[j]) outq.push_back(str[j]);
    end
    check({tag, "_decode_len"}, outq.size(), sym_q.size());
    for (int i = 0; i < outq.size() && i < sym_q.size(); i++)
      if (outq[i] != sym_q[i]) mism++;
    check({tag, "_decode_mismatches"}, mism, 0);
  endtask

  initial begin
    tb_rst = 1; tb_valid = 0; tb_last = 0; tb_cready = 1; tb_sym = 0; sel = 0;
    stall_mode = 0; gap_mode = 0;

    // Test 1: banana_bandana, free-running output
    test_id = 1;
    do_reset(0); m_reset(10, 0); load_banana();
    run_stream(-1); after_stream(); check_banana();

    // Test 2: lone symbol with last from IDLE
    test_id = 2;
    do_reset(0); m_reset(10, 0);
    sym_q.delete(); last_q.delete();
    sym_q.push_back('h41); last_q.push_back(1'b1);
    run_stream(-1); after_stream();
    check("t2_code", (got_code_q.size() > 0) ? got_code_q[0] : -1, 'h41);
    check("t2_dict_size", o_dsize, 257);

    // Test 3: Test 1 with 3-cycle back-pressure after each code
    test_id = 3; stall_mode = 1;
    do_reset(0); m_reset(10, 0); load_banana();
    run_stream(-1); after_stream(); check_banana();
    stall_mode = 0;

    // Test 4: 9-bit codes, restart on full
    for (int i = 0; i < 2000; i++) rnd_q.push_back($urandom_range(0, 7));
    test_id = 4; gap_mode = 1;
    do_reset(1); m_reset(9, 1);
    sym_q = rnd_q; last_q.delete();
    for (int i = 0; i < 2000; i++) last_q.push_back(i == 1999);
    run_stream(-1); after_stream();
    check("t4_clear_seen", (clears > 0) ? 1 : 0, 1);
    decode_check("t4", 9);

    // Test 5: 9-bit codes, freeze on full
    test_id = 5;
    do_reset(2); m_reset(9, 0);
    run_stream(-1); after_stream();
    check("t5_clear_count", clears, 0);
    check("t5_dict_saturated", o_dsize, 512);
    decode_check("t5", 9);
    gap_mode = 0;

    // Test 6: reset mid-message while a code is pending
    test_id = 6;
    do_reset(0); m_reset(10, 0); load_banana();
    run_stream(5);
    tb_rst = 1;
    @(negedge clk);
    tb_rst = 0;
    #1;
    check("t6_code_valid_after_reset", int'(o_cvalid), 0);
    check("t6_dict_size_after_reset", o_dsize, 257);
    check("t6_sym_ready_after_reset", int'(o_sready), 1);
    m_reset(10, 0);
    run_stream(-1); after_stream(); check_banana();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lzw_stream_encoder.md
LZW_STREAM_ENCODER -- requirements
Module: lzw_stream_encoder

Interface
REQ-001 SHALL have parameter SYM_W, default 8, input symbol width in bits.
REQ-002 SHALL have parameter CODE_W, default 10, output code width; legal range SYM_W+2..12.
REQ-003 SHALL have parameter FULL_RESET, default 0, dictionary-full policy: 0 = freeze, 1 = emit CLEAR and restart.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit, reset; synchronous and active-high.
REQ-006 SHALL have port sym_i, input, SYM_W bits, input symbol.
REQ-007 SHALL have port sym_valid_i, input, 1 bit, symbol valid.
REQ-008 SHALL have port sym_last_i, input, 1 bit, marks the final symbol of a message.
REQ-009 SHALL have port sym_ready_o, output, 1 bit, encoder accepts a symbol this cycle.
REQ-010 SHALL have port code_o, output, CODE_W bits, emitted code.
REQ-011 SHALL have port code_valid_o, output, 1 bit, code_o valid.
REQ-012 SHALL have port code_last_o, output, 1 bit, final code of the message.
REQ-013 SHALL have port code_ready_i, input, 1 bit, downstream accepts the code.
REQ-014 SHALL have port dict_size_o, output, CODE_W+1 bits, next free code.
REQ-015 SHALL have port busy_o, output, 1 bit, high in any state other than IDLE.

Function
REQ-016 Code map SHALL be: 0..2^SYM_W-1 literals; CLEAR = 2^SYM_W (reserved); first allocated code FIRST = 2^SYM_W+1; last allocated code MAX = 2^CODE_W-1.
REQ-017 Dictionary SHALL hold (prefix code, symbol) pairs for codes FIRST..MAX; an entry is live iff its code < dict_size_o; lookup SHALL be a single-cycle parallel match over live entries.
REQ-018 A symbol transfer SHALL occur iff sym_valid_i && sym_ready_o; a code transfer SHALL occur iff code_valid_o && code_ready_i.
REQ-019 sym_ready_o SHALL equal (state is IDLE or ACCUM) && (!code_valid_o || code_ready_i).
REQ-020 FSM states SHALL be IDLE (no current string), ACCUM (current string code W held), CLR (CLEAR pending), FLUSH (final code pending).
REQ-021 IDLE, accepted symbol c: W=c, go to ACCUM; if sym_last_i, register code c with last=1 and stay in IDLE.
REQ-022 ACCUM, accepted c with (W,c) live at code k (hit): W=k; if sym_last_i, register W=k with last=1 and go to IDLE.
REQ-023 ACCUM, accepted c on a miss: register code W with last=0; if dict_size_o <= MAX, write (W,c) at dict_size_o and increment it; set W=c; if sym_last_i, go to FLUSH.
REQ-024 FLUSH: when the output register is free, register W with last=1 and go to IDLE.
REQ-025 FULL_RESET=1: the miss that allocates MAX SHALL route next to CLR; CLR registers CLEAR when the output register is free, sets dict_size_o=FIRST, then goes to FLUSH if the last flag was captured, else ACCUM.
REQ-026 FULL_RESET=0: when dict_size_o = MAX+1, no further allocation; hits on existing entries continue.
REQ-027 Latency: a registered code SHALL appear on code_o with code_valid_o high the cycle after the symbol transfer; code_o and code_last_o SHALL hold stable while code_valid_o && !code_ready_i.
REQ-028 A symbol with sym_last_i SHALL produce exactly one code with code_last_o=1; the dictionary persists across messages.
REQ-029 sym_i and sym_last_i SHALL be ignored when no symbol transfer occurs.

Reset
REQ-030 On reset_i high at a clock edge: state=IDLE, code_valid_o=0, code_last_o=0, code_o=0, dict_size_o=FIRST, busy_o=0, W=0; any in-flight code is dropped; reset overrides all simultaneous transfers.
REQ-031 sym_ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Test 1: defaults; stream "banana_bandana" (last on final 'a'), code_ready_i=1 -> codes 0x062,0x061,0x06E,0x102,0x061,0x05F,0x101,0x06E,0x064,0x104 with last on 0x104; dict_size_o=266.
REQ-033 Test 2: single symbol 0x41 with last in IDLE -> next cycle code 0x041 with last=1; dict_size_o stays 257.
REQ-034 Test 3: Test 1 with code_ready_i low for 3 cycles after each code -> identical code sequence, code_o stable while stalled, sym_ready_o low while stalled.
REQ-035 Test 4: CODE_W=9, FULL_RESET=1, pseudo-random stream of 2000 symbols -> CLEAR (256) emitted right after the miss allocating 511; dict_size_o returns to 257; reference-model decode matches the input.
REQ-036 Test 5: CODE_W=9, FULL_RESET=0, same stream -> no CLEAR; dict_size_o saturates at 512; decode matches.
REQ-037 Test 6: reset_i pulsed mid-message with code_valid_o high -> next cycle code_valid_o=0, dict_size_o=257; a subsequent Test 1 stream reproduces the Test 1 output.
